// File: rtl/fb_pkg.sv
// Shared types and constants for the frame-buffer write master: layout of the
// 640x480 buffer (one 32-bit word per pixel, 8-byte stride) and the queued write record.
package fb_pkg;

    localparam int H_RES           = 640;
    localparam int V_RES           = 480;
    localparam int BYTES_PER_PIXEL = 8;
    localparam int FB_PIXELS       = H_RES * V_RES;
    localparam int ADDR_W          = 26;
    localparam int DATA_W          = 32;

    typedef enum logic [1:0] {
        S_PIXEL,
        S_DRAIN,
        S_CLEAR
    } fbw_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } fb_wr_t;

    // Byte offset of a linear pixel index inside the buffer.
    function automatic logic [ADDR_W-1:0] pixel_offset(input logic [ADDR_W-1:0] index);
        return index << $clog2(BYTES_PER_PIXEL);
    endfunction

endpackage

// File: rtl/fb_write_fifo.sv
// Synchronous first-word-fall-through FIFO of frame-buffer write records.
// Push while full and pop while empty are ignored.
module fb_write_fifo
    import fb_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   push,
    input  fb_wr_t din,
    input  logic   pop,
    output fb_wr_t dout,
    output logic   full,
    output logic   empty
);

    localparam int PW = $clog2(DEPTH);

    fb_wr_t        mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          push_ok, pop_ok;

    assign full    = (count_q == (PW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/fb_write_master.sv
// Rasterizer pixel writes and back-buffer fill, issued as Avalon-MM writes.
// A pixel arriving at an empty, free output bypasses the queue so it is on the bus next cycle.
module fb_write_master
    import fb_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int H_RES      = fb_pkg::H_RES,
    parameter int V_RES      = fb_pkg::V_RES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [25:0] back_base,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [9:0]  pix_x,
    input  logic [8:0]  pix_y,
    input  logic [31:0] pix_color,
    input  logic        clear_start,
    input  logic [31:0] clear_color,
    output logic        clear_busy,
    output logic        idle,
    output logic [25:0] master_address,
    output logic        master_write,
    output logic [31:0] master_writedata,
    input  logic        master_waitrequest
);

    localparam int FILL_TOTAL = H_RES * V_RES;
    localparam int CW         = $clog2(FILL_TOTAL + 1);

    fbw_state_t    state_q, state_d;
    logic          alive_q;
    logic          clear_busy_q, clear_busy_d;
    logic [CW-1:0] clr_cnt_q, clr_cnt_d;
    logic [25:0]   clr_base_q, clr_base_d;
    logic [31:0]   clr_color_q, clr_color_d;
    logic          write_q, write_d;
    fb_wr_t        wr_q, wr_d;

    logic   fifo_push, fifo_pop, fifo_full, fifo_empty;
    fb_wr_t fifo_dout, pix_wr;
    logic   in_range, pix_take, out_free;

    fb_write_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .din   (pix_wr),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign pix_ready   = alive_q && (state_q == S_PIXEL) && !fifo_full;
    assign in_range    = (32'(pix_x) < H_RES) && (32'(pix_y) < V_RES);
    assign pix_take    = pix_valid && pix_ready && in_range;
    assign pix_wr.addr = back_base + pixel_offset(26'(pix_x) + 26'(H_RES) * 26'(pix_y));
    assign pix_wr.data = pix_color;
    // The output register may take a new write when idle or when its current one completes.
    assign out_free    = !write_q || !master_waitrequest;

    assign master_write     = write_q;
    assign master_address   = wr_q.addr;
    assign master_writedata = wr_q.data;
    assign clear_busy       = clear_busy_q;
    assign idle             = alive_q && (state_q == S_PIXEL) && fifo_empty && !write_q;

    always_comb begin
        state_d      = state_q;
        clear_busy_d = clear_busy_q;
        clr_cnt_d    = clr_cnt_q;
        clr_base_d   = clr_base_q;
        clr_color_d  = clr_color_q;
        write_d      = write_q;
        wr_d         = wr_q;
        fifo_push    = 1'b0;
        fifo_pop     = 1'b0;
        if (out_free) write_d = 1'b0;

        case (state_q)
            S_PIXEL, S_DRAIN: begin
                if (out_free && !fifo_empty) begin
                    fifo_pop = 1'b1;
                    wr_d     = fifo_dout;
                    write_d  = 1'b1;
                end else if (out_free && pix_take) begin
                    wr_d    = pix_wr;
                    write_d = 1'b1;
                end
                fifo_push = pix_take && !(out_free && fifo_empty);

                if (state_q == S_PIXEL && alive_q && clear_start) begin
                    clr_base_d   = back_base;
                    clr_color_d  = clear_color;
                    clr_cnt_d    = '0;
                    clear_busy_d = 1'b1;
                    state_d      = S_DRAIN;
                end
                if (state_q == S_DRAIN && fifo_empty && !write_q) state_d = S_CLEAR;
            end

            S_CLEAR: begin
                // clr_cnt counts fill writes handed to the bus; the next is issued only
                // once the previous one has completed.
                if (out_free && clr_cnt_q < CW'(FILL_TOTAL)) begin
                    wr_d.addr = clr_base_q + pixel_offset(26'(clr_cnt_q));
                    wr_d.data = clr_color_q;
                    write_d   = 1'b1;
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
                if (write_q && !master_waitrequest && clr_cnt_q == CW'(FILL_TOTAL)) begin
                    clr_cnt_d    = '0;
                    clear_busy_d = 1'b0;
                    state_d      = S_PIXEL;
                end
            end

            default: state_d = S_PIXEL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_PIXEL;
            alive_q      <= 1'b0;
            clear_busy_q <= 1'b0;
            clr_cnt_q    <= '0;
            clr_base_q   <= '0;
            clr_color_q  <= '0;
            write_q      <= 1'b0;
            wr_q         <= '0;
        end else begin
            state_q      <= state_d;
            alive_q      <= 1'b1;
            clear_busy_q <= clear_busy_d;
            clr_cnt_q    <= clr_cnt_d;
            clr_base_q   <= clr_base_d;
            clr_color_q  <= clr_color_d;
            write_q      <= write_d;
            wr_q         <= wr_d;
        end
    end

endmodule

// File: tb/tb_fb_write_master.sv
// Bench for fb_write_master: a frame of 640 x 16 keeps each fill short while
// keeping the real 640-pixel line stride.
module tb_fb_write_master;

    localparam int H     = 640;
    localparam int V     = 16;
    localparam int TOT   = H * V;
    localparam int DEPTH = 8;

    typedef struct packed {
        logic [25:0] addr;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [25:0] back_base;
    logic        pix_valid;
    logic        pix_ready;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic [31:0] pix_color;
    logic        clear_start;
    logic [31:0] clear_color;
    logic        clear_busy;
    logic        idle;
    logic [25:0] master_address;
    logic        master_write;
    logic [31:0] master_writedata;
    logic        master_waitrequest;

    always #5 clk = ~clk;

    fb_write_master #(.FIFO_DEPTH(DEPTH), .H_RES(H), .V_RES(V)) dut (
        .clk                (clk),
        .reset              (reset),
        .back_base          (back_base),
        .pix_valid          (pix_valid),
        .pix_ready          (pix_ready),
        .pix_x              (pix_x),
        .pix_y              (pix_y),
        .pix_color          (pix_color),
        .clear_start        (clear_start),
        .clear_color        (clear_color),
        .clear_busy         (clear_busy),
        .idle               (idle),
        .master_address     (master_address),
        .master_write       (master_write),
        .master_writedata   (master_writedata),
        .master_waitrequest (master_waitrequest)
    );

    // Reference model: expected pixel writes in acceptance order, then a pending fill.
    exp_t        exp_q[$];
    bit          m_busy, fill_on, prev_stall, rand_wait;
    int          fill_idx, fill_done;
    logic [25:0] fill_base, prev_a;
    logic [31:0] fill_color, prev_d;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic monitor_step();
        exp_t e;
        if (!reset) begin
            exp_q.delete();
            m_busy = 0; fill_on = 0; prev_stall = 0;
        end else begin
            n_cmp++;
            if (clear_busy !== m_busy) begin
                n_err++;
                $display("FAIL clear_busy: got %b want %b at %0t", clear_busy, m_busy, $time);
            end
            if (prev_stall) begin
                n_cmp++;
                if (master_write !== 1'b1 || master_address !== prev_a || master_writedata !== prev_d) begin
                    n_err++;
                    $display("FAIL stall_hold: got w=%b a=%h d=%h want w=1 a=%h d=%h",
                             master_write, master_address, master_writedata, prev_a, prev_d);
                end
            end
            if (master_write === 1'b1 && master_waitrequest === 1'b0) begin
                n_cmp++;
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    if (master_address !== e.addr || master_writedata !== e.data) begin
                        n_err++;
                        $display("FAIL pixel_write: got a=%h d=%h want a=%h d=%h",
                                 master_address, master_writedata, e.addr, e.data);
                    end
                end else if (fill_on) begin
                    e.addr = fill_base + 26'(fill_idx * 8);
                    e.data = fill_color;
                    if (master_address !== e.addr || master_writedata !== e.data) begin
                        n_err++;
                        $display("FAIL fill_write %0d: got a=%h d=%h want a=%h d=%h",
                                 fill_idx, master_address, master_writedata, e.addr, e.data);
                    end
                    fill_idx++;
                    if (fill_idx == TOT) begin
                        fill_on = 0; m_busy = 0; fill_done++;
                    end
                end else begin
                    n_err++;
                    $display("FAIL unexpected_write: got a=%h d=%h want no write",
                             master_address, master_writedata);
                end
            end
            prev_stall = (master_write === 1'b1) && (master_waitrequest === 1'b1);
            prev_a = master_address;
            prev_d = master_writedata;
            if (pix_valid && pix_ready === 1'b1 && int'(pix_x) < H && int'(pix_y) < V) begin
                e.addr = back_base + 26'((int'(pix_x) + H * int'(pix_y)) * 8);
                e.data = pix_color;
                exp_q.push_back(e);
            end
            if (clear_start && !m_busy) begin
                m_busy = 1; fill_on = 1; fill_idx = 0;
                fill_base = back_base; fill_color = clear_color;
            end
        end
    endtask

    // One clock: model samples at the falling edge, stimulus changes 1 time unit after the rising edge.
    task automatic tick();
        @(negedge clk);
        monitor_step();
        @(posedge clk);
        #1;
        if (rand_wait) master_waitrequest = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_drain(input int budget);
        bit done = 0;
        for (int c = 0; c < budget; c++) begin
            if (idle === 1'b1 && exp_q.size() == 0 && !fill_on) begin
                done = 1;
                break;
            end
            tick();
        end
        n_cmp++;
        if (!done) begin
            n_err++;
            $display("FAIL drain_timeout: got idle=%b pending=%0d want idle=1 pending=0", idle, exp_q.size());
        end
    endtask

    task automatic rand_pixel(input bit in_range_only);
        pix_x     = in_range_only ? 10'($urandom_range(0, H - 1)) : 10'($urandom_range(0, H + 40));
        pix_y     = in_range_only ? 9'($urandom_range(0, V - 1))  : 9'($urandom_range(0, V + 2));
        pix_color = {8'h00, 24'($urandom)};
    endtask

    task automatic test_reset();
        reset = 0; master_waitrequest = 0; back_base = '0;
        pix_valid = 1; pix_x = '0; pix_y = '0; pix_color = '0;
        clear_start = 1; clear_color = 32'h00ABCDEF;
        repeat (3) tick();
        n_cmp += 6;
        if (master_write !== 1'b0)       begin n_err++; $display("FAIL rst_write: got %b want 0", master_write); end
        if (master_address !== 26'h0)    begin n_err++; $display("FAIL rst_addr: got %h want 0", master_address); end
        if (master_writedata !== 32'h0)  begin n_err++; $display("FAIL rst_data: got %h want 0", master_writedata); end
        if (clear_busy !== 1'b0)         begin n_err++; $display("FAIL rst_busy: got %b want 0", clear_busy); end
        if (pix_ready !== 1'b0)          begin n_err++; $display("FAIL rst_ready: got %b want 0", pix_ready); end
        if (idle !== 1'b0)               begin n_err++; $display("FAIL rst_idle: got %b want 0", idle); end
        pix_valid = 0; clear_start = 0; reset = 1;
        tick();
        n_cmp += 3;
        if (pix_ready !== 1'b1)  begin n_err++; $display("FAIL post_rst_ready: got %b want 1", pix_ready); end
        if (idle !== 1'b1)       begin n_err++; $display("FAIL post_rst_idle: got %b want 1", idle); end
        if (clear_busy !== 1'b0) begin n_err++; $display("FAIL post_rst_busy: got %b want 0", clear_busy); end
        $display("test_reset done");
    endtask

    task automatic test_single_pixel();
        back_base = 26'h100000; pix_x = 10'd3; pix_y = 9'd2; pix_color = 32'h00FF0000; pix_valid = 1;
        n_cmp++;
        if (pix_ready !== 1'b1) begin n_err++; $display("FAIL single_ready: got %b want 1", pix_ready); end
        tick();
        pix_valid = 0;
        n_cmp += 3;
        if (master_write !== 1'b1)          begin n_err++; $display("FAIL single_write: got %b want 1", master_write); end
        if (master_address !== 26'h102818)  begin n_err++; $display("FAIL single_addr: got %h want 102818", master_address); end
        if (master_writedata !== 32'h00FF0000) begin n_err++; $display("FAIL single_data: got %h want 00ff0000", master_writedata); end
        tick();
        n_cmp++;
        if (master_write !== 1'b0) begin n_err++; $display("FAIL single_once: got %b want 0", master_write); end
        wait_drain(20);
        $display("test_single_pixel done");
    endtask

    task automatic test_backpressure();
        int acc = 0;
        int sent = 0;
        bit hs;
        master_waitrequest = 1;
        rand_pixel(1); pix_valid = 1;
        for (int c = 0; c < 14; c++) begin
            hs = pix_valid && pix_ready;
            tick();
            if (hs) begin
                acc++; sent++;
                if (sent < 10) rand_pixel(1); else pix_valid = 0;
            end
        end
        n_cmp += 2;
        if (acc != DEPTH + 1)   begin n_err++; $display("FAIL bp_accepts: got %0d want %0d", acc, DEPTH + 1); end
        if (pix_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready: got %b want 0", pix_ready); end
        master_waitrequest = 0;
        for (int c = 0; c < 60 && sent < 10; c++) begin
            hs = pix_valid && pix_ready;
            tick();
            if (hs) begin
                sent++;
                if (sent < 10) rand_pixel(1); else pix_valid = 0;
            end
        end
        pix_valid = 0;
        n_cmp++;
        if (sent != 10) begin n_err++; $display("FAIL bp_sent: got %0d want 10", sent); end
        wait_drain(60);
        $display("test_backpressure done");
    endtask

    task automatic test_out_of_range();
        for (int k = 0; k < 2; k++) begin
            pix_x = (k == 0) ? 10'(H) : 10'd0;
            pix_y = (k == 0) ? 9'd0 : 9'(V);
            pix_color = 32'h00C0FFEE; pix_valid = 1;
            n_cmp++;
            if (pix_ready !== 1'b1) begin n_err++; $display("FAIL oor_ready %0d: got %b want 1", k, pix_ready); end
            tick();
            pix_valid = 0;
        end
        for (int c = 0; c < 4; c++) begin
            n_cmp++;
            if (master_write !== 1'b0) begin n_err++; $display("FAIL oor_write: got %b want 0", master_write); end
            tick();
        end
        n_cmp++;
        if (idle !== 1'b1) begin n_err++; $display("FAIL oor_idle: got %b want 1", idle); end
        $display("test_out_of_range done");
    endtask

    task automatic test_random_pixels();
        int n = 0;
        bit hs;
        rand_wait = 1;
        rand_pixel(0); back_base = 26'($urandom); pix_valid = 1;
        for (int c = 0; c < 600 && n < 40; c++) begin
            hs = pix_valid && pix_ready;
            tick();
            if (hs) n++;
            rand_pixel(0);
            if ($urandom_range(0, 3) == 0) back_base = 26'($urandom);
            pix_valid = (n < 40) && ($urandom_range(0, 3) != 0);
        end
        pix_valid = 0; rand_wait = 0; master_waitrequest = 0;
        n_cmp++;
        if (n != 40) begin n_err++; $display("FAIL rand_accepts: got %0d want 40", n); end
        wait_drain(100);
        $display("test_random_pixels done");
    endtask

    task automatic test_clear();
        int got = 0;
        int fd = fill_done;
        bit hs;
        back_base = 26'h0; master_waitrequest = 1;
        rand_pixel(1); pix_valid = 1;
        for (int c = 0; c < 20 && got < 3; c++) begin
            hs = pix_valid && pix_ready;
            tick();
            if (hs) begin got++; rand_pixel(1); end
        end
        pix_valid = 0;
        clear_start = 1; clear_color = 32'h00123456;
        tick();
        clear_start = 0; clear_color = 32'h00DEAD00; back_base = 26'h3000;
        n_cmp += 2;
        if (clear_busy !== 1'b1) begin n_err++; $display("FAIL clr_busy_rise: got %b want 1", clear_busy); end
        if (pix_ready !== 1'b0)  begin n_err++; $display("FAIL clr_ready: got %b want 0", pix_ready); end
        master_waitrequest = 0;
        for (int c = 0; c < TOT + 200; c++) begin
            clear_start = (c == 100);
            tick();
            if (clear_busy !== 1'b1) break;
        end
        clear_start = 0;
        n_cmp += 3;
        if (fill_done != fd + 1)  begin n_err++; $display("FAIL clr_fill_count: got %0d want %0d", fill_done - fd, 1); end
        if (clear_busy !== 1'b0)  begin n_err++; $display("FAIL clr_busy_fall: got %b want 0", clear_busy); end
        if (pix_ready !== 1'b1)   begin n_err++; $display("FAIL clr_ready_back: got %b want 1", pix_ready); end
        wait_drain(20);
        $display("test_clear done");
    endtask

    task automatic test_clear_random_wait();
        int fd = fill_done;
        back_base = 26'($urandom); clear_color = {8'h00, 24'($urandom)};
        clear_start = 1;
        tick();
        clear_start = 0;
        rand_wait = 1;
        for (int c = 0; c < 5 * TOT; c++) begin
            tick();
            if (clear_busy !== 1'b1) break;
        end
        rand_wait = 0; master_waitrequest = 0;
        n_cmp += 2;
        if (fill_done != fd + 1) begin n_err++; $display("FAIL rclr_fill_count: got %0d want 1", fill_done - fd); end
        if (clear_busy !== 1'b0) begin n_err++; $display("FAIL rclr_busy: got %b want 0", clear_busy); end
        wait_drain(20);
        $display("test_clear_random_wait done");
    endtask

    task automatic test_reset_mid_fill();
        back_base = 26'h0; clear_color = 32'h00777777;
        clear_start = 1;
        tick();
        clear_start = 0;
        repeat (50) tick();
        master_waitrequest = 1;
        repeat (2) tick();
        reset = 0;
        tick();
        n_cmp += 3;
        if (master_write !== 1'b0) begin n_err++; $display("FAIL mid_rst_write: got %b want 0", master_write); end
        if (clear_busy !== 1'b0)   begin n_err++; $display("FAIL mid_rst_busy: got %b want 0", clear_busy); end
        if (pix_ready !== 1'b0)    begin n_err++; $display("FAIL mid_rst_ready: got %b want 0", pix_ready); end
        reset = 1; master_waitrequest = 0;
        tick();
        n_cmp++;
        if (pix_ready !== 1'b1) begin n_err++; $display("FAIL mid_rel_ready: got %b want 1", pix_ready); end
        back_base = 26'h200; pix_x = 10'd5; pix_y = 9'd7; pix_color = 32'h00010203; pix_valid = 1;
        tick();
        pix_valid = 0;
        n_cmp += 2;
        if (master_write !== 1'b1)         begin n_err++; $display("FAIL mid_pix_write: got %b want 1", master_write); end
        if (master_address !== 26'h8E28)   begin n_err++; $display("FAIL mid_pix_addr: got %h want 8e28", master_address); end
        wait_drain(20);
        $display("test_reset_mid_fill done");
    endtask

    initial begin
        rand_wait = 0; m_busy = 0; fill_on = 0; prev_stall = 0; fill_idx = 0; fill_done = 0;
        test_reset();
        test_single_pixel();
        test_backpressure();
        test_out_of_range();
        test_random_pixels();
        test_clear();
        test_clear_random_wait();
        test_reset_mid_fill();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fb_write_master.md
Name: fb_write_master

Overview:
- Upstream neighbour of the VGA read path. It takes rasterizer pixel writes as (x, y, colour) with a valid/ready handshake.
- It converts each pixel to an SDRAM frame-buffer address and issues Avalon-MM writes.
- It provides a whole-buffer clear (fill) operation on the back buffer.
- The frame-buffer layout matches the display reader: one 32-bit word per pixel, 8-byte stride, row-major, 640x480.

Parameters:
- FIFO_DEPTH, 8: pixel write queue entries; must be a power of two, ≥2.
- H_RES, 640: active pixels per line.
- V_RES, 480: active lines per frame.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- back_base  in  26  byte address of back-buffer pixel (0,0); sampled per accepted pixel and at clear start
- pix_valid  in  1  rasterizer offers a pixel
- pix_ready  out  1  block accepts the pixel this cycle
- pix_x  in  10  pixel column
- pix_y  in  9  pixel row
- pix_color  in  32  pixel word {8'h0, B, G, R}
- clear_start  in  1  one-cycle pulse: fill back buffer with clear_color
- clear_color  in  32  fill word, sampled with clear_start
- clear_busy  out  1  high from accepted clear_start until the last fill write completes
- idle  out  1  high when the FIFO is empty, no write is pending, and state = S_PIXEL
- master_address  out  26  Avalon byte address
- master_write  out  1  Avalon write request
- master_writedata  out  32  Avalon write data
- master_waitrequest  in  1  Avalon stall

Behaviour:
- Reset is synchronous, active-low, on clk. The whole block resets:
  - master_write = 0, master_address = 0, master_writedata = 0;
  - clear_busy = 0, pix_ready = 0, idle = 0;
  - FIFO emptied, state S_PIXEL, clear counter = 0.
- First cycle after reset release: pix_ready = 1, idle = 1.
- Reset mid-operation abandons the queued and in-flight writes and the clear. master_write drops in the same cycle reset is sampled.
- Pixel acceptance: a handshake occurs when pix_valid && pix_ready. pix_ready = (state == S_PIXEL) && !fifo_full.
- Address = back_base + (pix_x + H_RES*pix_y)*8. Computed in 26 bits, truncated modulo 2^26.
- Out-of-range pixels (pix_x ≥ H_RES or pix_y ≥ V_RES) are accepted (handshake completes) and silently dropped, never enqueued.
- Enqueue {address, colour} (58 bits). A pixel accepted in cycle N can assert master_write no earlier than N+1. Output is registered.
- Avalon master rules:
  - A write completes on a cycle with master_write && !master_waitrequest.
  - While master_waitrequest = 1, master_address and master_writedata are held stable and master_write stays high.
  - After completion, the next entry is presented in the following cycle if one is available. Back-to-back throughput is 1 write/cycle when waitrequest stays low.
  - Writes leave the block strictly in acceptance order.
- FIFO full/empty:
  - Full: pix_ready = 0.
  - Simultaneous enqueue and dequeue on a full FIFO is not permitted, because ready is already low.
  - Simultaneous enqueue and dequeue on a non-empty, non-full FIFO keeps the count unchanged.
- State machine:
  - S_PIXEL: normal operation. A clear_start in this state latches clear_color and back_base, sets clear_busy = 1 in the next cycle, and moves to S_DRAIN. If clear_start and a pixel handshake coincide, the pixel is accepted first and written before the fill.
  - S_DRAIN: pix_ready = 0. Move to S_CLEAR once the FIFO is empty and no write is pending.
  - S_CLEAR: issue H_RES*V_RES = 307200 writes at latched_base + i*8, for i = 0 to 307199, all with latched clear_color, under the same waitrequest rules. The counter advances only on write completion. When write i = 307199 completes, set clear_busy = 0 and return to S_PIXEL; pix_ready returns the next cycle.
- clear_start while clear_busy = 1 is ignored. clear_start during reset is ignored.
- idle = (state == S_PIXEL) && fifo_empty && !master_write.

Decomposition:
- Package fb_pkg:
  - H_RES, V_RES, BYTES_PER_PIXEL = 8, FB_PIXELS = 307200;
  - typedef fbw_state_t {S_PIXEL, S_DRAIN, S_CLEAR};
  - typedef struct packed {logic [25:0] addr; logic [31:0] data;} fb_wr_t.
- One sub-module: fb_write_fifo, a synchronous FIFO of fb_wr_t.
  - Parameter DEPTH; synchronous active-low reset.
  - Outputs full, empty and first-word-fall-through dout.

Test Plan:
- Reset, then back_base = 0x100000, one pixel (x = 3, y = 2, colour = 0x00FF0000) with waitrequest = 0 → exactly one write at 0x100000 + (3 + 1280)*8 = 0x10281 8 → address 0x102818, data 0x00FF0000, 1 cycle high, issued cycle N+1.
- Hold waitrequest = 1 for 5 cycles with 10 pixels offered back-to-back → pix_ready drops after 8 accepts (plus the in-flight entry); master_address and master_writedata stay stable across the stall; all 10 writes emerge in order once waitrequest = 0.
- Pixel x = 640, y = 0 and pixel x = 0, y = 480 → both handshake, no Avalon write, idle returns to 1.
- clear_start with clear_color = 0x00123456, base 0, and 3 pixels queued → the 3 pixel writes complete first, then 307200 fill writes from 0x0 to 0x257FF8 step 8; clear_busy falls the cycle after the last completion; a second clear_start mid-fill is ignored.
- Random waitrequest (50%) during the fill → the write count equals 307200 exactly and no address is skipped or repeated.
- Assert reset mid-fill while waitrequest = 1 → the next cycle has master_write = 0, clear_busy = 0, pix_ready = 0; after release, pix_ready = 1 and a new pixel writes normally.
